// File: rtl/lo_sequencer_if.sv
// lo_sequencer_if: configuration handshake and LO outputs of lo_sequencer; lo_reverse exists only with LO_REVERSE_EN.
interface lo_sequencer_if #(parameter int DIV_W = 8);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_phase;
  logic             stop_req;
  logic [1:0]       lo_i;
  logic [1:0]       lo_q;
  logic             step_o;
  logic             busy;
  logic             done;
  logic             mix_valid;
`ifdef LO_REVERSE_EN
  logic             lo_reverse;
  modport master (output cfg_valid, cfg_div, cfg_phase, stop_req, lo_reverse,
                  input cfg_ready, lo_i, lo_q, step_o, busy, done, mix_valid);
  modport slave (input cfg_valid, cfg_div, cfg_phase, stop_req, lo_reverse,
                 output cfg_ready, lo_i, lo_q, step_o, busy, done, mix_valid);
`else
  modport master (output cfg_valid, cfg_div, cfg_phase, stop_req,
                  input cfg_ready, lo_i, lo_q, step_o, busy, done, mix_valid);
  modport slave (input cfg_valid, cfg_div, cfg_phase, stop_req,
                 output cfg_ready, lo_i, lo_q, step_o, busy, done, mix_valid);
`endif
endinterface

// File: rtl/lo_sequencer.sv
// lo_sequencer: quadrature LO phase sequencer with step divider and phase-0 aligned stop.
// Optional LO_REVERSE_EN adds lo_reverse, which runs the index downward (negative-frequency LO).
module lo_sequencer #(parameter int DIV_W = 8) (
  input logic           clock,
  input logic           reset,
  lo_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t           state, state_n;
  logic [DIV_W-1:0] div_q, div_n, cnt, cnt_n;
  logic [1:0]       idx, idx_n, idx_step;
  logic             rev, wrap, at_div, step_n, done_n, busy_n;
`ifdef LO_REVERSE_EN
  always_ff @(posedge clock)
    if (reset) rev <= 1'b0;
    else if (bus.cfg_valid && bus.cfg_ready) rev <= bus.lo_reverse;
`else
  assign rev = 1'b0;
`endif
  // wrap marks the step that would return to the run's termination boundary
  assign wrap     = rev ? (idx == 2'd0) : (idx == 2'd3);
  assign idx_step = rev ? idx - 2'd1 : idx + 2'd1;
  assign at_div   = cnt == div_q;
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    div_n   = div_q;
    step_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: if (bus.cfg_valid && bus.cfg_ready) begin
        state_n = RUN;
        idx_n   = bus.cfg_phase;
        cnt_n   = '0;
        div_n   = bus.cfg_div;
      end
      RUN, STOP: begin
        if (state == RUN && bus.stop_req) state_n = STOP;
        if (at_div) begin
          cnt_n  = '0;
          idx_n  = idx_step;
          step_n = 1'b1;
          if (state == STOP && wrap) begin
            state_n = IDLE;
            step_n  = 1'b0;
            done_n  = 1'b1;
          end
        end else cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state         <= IDLE;
      idx           <= 2'd0;
      cnt           <= '0;
      div_q         <= '0;
      bus.cfg_ready <= 1'b1;
      bus.lo_i      <= 2'b00;
      bus.lo_q      <= 2'b00;
      bus.step_o    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mix_valid <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      cnt           <= cnt_n;
      div_q         <= div_n;
      bus.cfg_ready <= !busy_n;
      bus.lo_i      <= !busy_n ? 2'b00 : idx_n == 2'd0 ? 2'b01 : idx_n == 2'd2 ? 2'b10 : 2'b00;
      bus.lo_q      <= !busy_n ? 2'b00 : idx_n == 2'd1 ? 2'b01 : idx_n == 2'd3 ? 2'b10 : 2'b00;
      bus.step_o    <= step_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
      bus.mix_valid <= bus.busy;
    end
endmodule

// File: tb/tb_lo_sequencer.sv
// tb_lo_sequencer: scoreboard bench; each run's per-clock outputs are predicted from the phase arithmetic.
module tb_lo_sequencer;
  localparam int DIV_W = 8;
  typedef logic [8:0] obs_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clock = ~clock;
  lo_sequencer_if #(.DIV_W(DIV_W)) bus ();
  lo_sequencer #(.DIV_W(DIV_W)) dut (.clock(clock), .reset(reset), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // {lo_i, lo_q, step_o, busy, done, mix_valid, cfg_ready}
  function automatic obs_t obs();
    return {bus.lo_i, bus.lo_q, bus.step_o, bus.busy, bus.done, bus.mix_valid, bus.cfg_ready};
  endfunction
  function automatic int phase_at(int ph, int p, bit rev, int t);
    return rev ? (((ph - t / p) % 4) + 4) % 4 : (ph + t / p) % 4;
  endfunction
  function automatic obs_t lo_rec(int idx, bit step, bit mix);
    logic [1:0] li, lq;
    li = idx == 0 ? 2'b01 : idx == 2 ? 2'b10 : 2'b00;
    lq = idx == 1 ? 2'b01 : idx == 3 ? 2'b10 : 2'b00;
    return {li, lq, step, 1'b1, 1'b0, mix, 1'b0};
  endfunction
  initial forever begin
    @(negedge clock);
    if (bus.busy || bus.done || bus.mix_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h expected no activity at %0t", obs(), $time);
      end else chk("out", 32'(obs()), 32'(exp_q.pop_front()));
    end
  end
  // d: divider, ph: start phase, k: edge carrying stop_req, rst_at: edge carrying reset (0 = none)
  task automatic run(input int d, input int ph, input bit rev, input int k, input int rst_at, input bit b2b);
    int p, t_end, last, w, ra;
    p = d + 1;
    ra = rst_at;
    w = 0;
    while (!bus.cfg_ready && w < 100) begin
      @(posedge clock); #1;
      w++;
    end
    if (!bus.cfg_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_ready_timeout: got 0 expected 1 at %0t", $time);
      return;
    end
    t_end = k + 1;
    while (!(t_end % p == 0 && phase_at(ph, p, rev, t_end) == (rev ? 3 : 0))) t_end++;
    if (ra > t_end) ra = 0;
    last = ra > 0 ? ra - 1 : t_end;
    for (int t = 0; t <= last; t++)
      exp_q.push_back(t == t_end ? obs_t'(9'b0000_0011_1) :
                      lo_rec(phase_at(ph, p, rev, t), t > 0 && t % p == 0, t >= 1));
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = DIV_W'(d);
    bus.cfg_phase = 2'(ph);
`ifdef LO_REVERSE_EN
    bus.lo_reverse = rev;
`endif
    bus.stop_req = 1'($urandom % 2);
    @(posedge clock); #1;
    bus.cfg_valid = b2b;
    for (int t = 1; t <= (ra > 0 ? ra : t_end); t++) begin
      bus.stop_req = (t == k) || (t > k && $urandom % 4 == 0);
      reset = (t == ra);
      @(posedge clock); #1;
    end
    bus.stop_req = 1'b0;
    reset = 1'b0;
    if (ra > 0) chk("after_reset", 32'(obs()), 32'h001);
  endtask
  initial begin
    bit rev;
    int ra;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_phase = 2'd0;
    bus.stop_req  = 1'b0;
`ifdef LO_REVERSE_EN
    bus.lo_reverse = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", 32'(obs()), 32'h001);
    reset = 1'b0;
    bus.stop_req = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
      chk("idle_stop_ignored", 32'(obs()), 32'h001);
    end
    bus.stop_req = 1'b0;
    run(0, 0, 1'b0, 4, 0, 1'b0);
    run(3, 0, 1'b0, 2, 0, 1'b0);
    run(1, 2, 1'b0, 1, 0, 1'b0);
    run(1, 0, 1'b0, 20, 3, 1'b0);
    run(0, 3, 1'b0, 1, 0, 1'b0);
    run(2, 1, 1'b0, 3, 0, 1'b1);
    run(0, 2, 1'b0, 2, 0, 1'b0);
`ifdef LO_REVERSE_EN
    run(0, 0, 1'b1, 2, 0, 1'b0);
`endif
    repeat (16) begin
      rev = 1'b0;
`ifdef LO_REVERSE_EN
      rev = 1'($urandom % 2);
`endif
      ra = ($urandom % 5 == 0) ? int'($urandom_range(1, 6)) : 0;
      run(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), rev,
          int'($urandom_range(1, 10)), ra, 1'($urandom % 3 == 0));
    end
    bus.cfg_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
